polar_encoder: RTL

Systematic-free (non-systematic) polar encoder, x = u·F^⊗n with F = [[1,0],[1,1]]. It is the transmit-side counterpart of the SC decoder datapath. It accepts an N-bit input vector u in W-bit beats and computes the codeword in log2(N) iterative butterfly stages over an internal N_MAX-bit register. It then streams the codeword out in W-bit beats. It feeds the channel model and the decoder testbench.

---
 rtl/polar_encoder.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/polar_encoder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : polar_encoder
// Description : Non-systematic polar encoder x = u * F^(kron n), F = [[1,0],[1,1]].
//               Loads u in W-bit beats, runs n in-place butterfly stages over
//               an N_MAX-bit register, then streams the codeword in W-bit beats.
//               Optional macro BIT_REV_EN emits the codeword in bit-reversed
//               (low n bits) index order instead of natural order.
// Revision    : 1.0 - initial release
// ============================================================================
module polar_encoder #(
  parameter int N_MAX = 512,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   n_sel,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last,
  output logic         busy
);

  localparam int c_LOG2_NMAX = $clog2(N_MAX);
  localparam int c_LOG2_NMIN = 7;
  localparam int c_LOG2_W    = $clog2(W);
  localparam int c_BEATS_MAX = N_MAX / W;
  localparam int c_BW        = $clog2(c_BEATS_MAX + 1);
  localparam int c_NW        = $clog2(c_LOG2_NMAX + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_ENC  = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t            r_state;
  logic [N_MAX-1:0]  r_x;
  logic [c_BW-1:0]   r_beat;
  logic [c_NW-1:0]   r_stage;
  logic [c_NW-1:0]   r_n;

  logic [c_NW-1:0]   w_n_in;
  logic [c_BW-1:0]   w_last_in;
  logic [c_BW-1:0]   w_last;
  logic [N_MAX-1:0]  w_stage_x;
  logic [N_MAX-1:0]  w_enc_final;

`ifdef BIT_REV_EN
  // Reorders the low 2^n bits so that position i holds x[bitrev_n(i)].
  function automatic logic [N_MAX-1:0] f_bitrev(input logic [N_MAX-1:0] x,
                                                input logic [c_NW-1:0] n);
    logic [N_MAX-1:0] y;
    int r;
    y = '0;
    for (int nn = c_LOG2_NMIN; nn <= c_LOG2_NMAX; nn++) begin
      if (int'(n) == nn) begin
        for (int i = 0; i < (1 << nn); i++) begin
          r = 0;
          for (int b = 0; b < nn; b++) begin
            if (((i >> b) & 1) == 1) r = r | (1 << (nn - 1 - b));
          end
          y[i] = x[r];
        end
      end
    end
    return y;
  endfunction
`endif

  // Map the code-length select to n; the reserved code and anything above
  // the supported maximum fall back to the largest length.
  always_comb begin
    case (n_sel)
      2'd0:    w_n_in = c_NW'(c_LOG2_NMIN);
      2'd1:    w_n_in = c_NW'(c_LOG2_NMIN + 1);
      default: w_n_in = c_NW'(c_LOG2_NMIN + 2);
    endcase
    if (int'(w_n_in) > c_LOG2_NMAX) w_n_in = c_NW'(c_LOG2_NMAX);
  end

  // Index of the final beat for the incoming and for the latched code length.
  always_comb begin
    w_last_in = c_BW'((1 << (int'(w_n_in) - c_LOG2_W)) - 1);
    w_last    = c_BW'((1 << (int'(r_n) - c_LOG2_W)) - 1);
  end

  // One butterfly stage: x[i] ^= x[i + 2^s] wherever bit s of i is clear.
  // Bits at or above N are zero, so running the stage over the full register
  // leaves them untouched and never disturbs the active part.
  always_comb begin
    w_stage_x = r_x;
    for (int s = 0; s < c_LOG2_NMAX; s++) begin
      if (r_stage == c_NW'(s)) begin
        for (int i = 0; i < N_MAX; i++) begin
          if (((i >> s) & 1) == 0) w_stage_x[i] = r_x[i] ^ r_x[i | (1 << s)];
        end
      end
    end
  end

  // Output ordering is folded into the last stage so OUT is a plain shifter.
`ifdef BIT_REV_EN
  assign w_enc_final = f_bitrev(w_stage_x, r_n);
`else
  assign w_enc_final = w_stage_x;
`endif

  // Control FSM, codeword register and beat/stage counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_x     <= '0;
      r_beat  <= '0;
      r_stage <= '0;
      r_n     <= c_NW'(c_LOG2_NMIN);
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_x     <= {{(N_MAX - W){1'b0}}, in_data};
            r_n     <= w_n_in;
            r_stage <= '0;
            if (w_last_in == '0) begin
              r_beat  <= '0;
              r_state <= S_ENC;
            end else begin
              r_beat  <= c_BW'(1);
              r_state <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            r_x[r_beat*W +: W] <= in_data;
            if (r_beat == w_last) begin
              r_beat  <= '0;
              r_stage <= '0;
              r_state <= S_ENC;
            end else begin
              r_beat <= r_beat + c_BW'(1);
            end
          end
        end
        S_ENC: begin
          if (r_stage == r_n - c_NW'(1)) begin
            r_x     <= w_enc_final;
            r_beat  <= '0;
            r_state <= S_OUT;
          end else begin
            r_x     <= w_stage_x;
            r_stage <= r_stage + c_NW'(1);
          end
        end
        default: begin
          if (out_ready) begin
            r_x <= r_x >> W;
            if (r_beat == w_last) begin
              r_beat  <= '0;
              r_state <= S_IDLE;
            end else begin
              r_beat <= r_beat + c_BW'(1);
            end
          end
        end
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE) || (r_state == S_LOAD);
  assign out_valid = (r_state == S_OUT);
  assign out_data  = out_valid ? r_x[W-1:0] : '0;
  assign out_last  = out_valid && (r_beat == w_last);
  assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire
